// File: rtl/pim_instr_encoder_if.sv
// Command and instruction-word handshake bundle for pim_instr_encoder.
// master drives commands and consumes words; slave is the encoder.
interface pim_instr_encoder_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [5:0]  cmd_opcode;
  logic [4:0]  cmd_rd;
  logic [4:0]  cmd_ra;
  logic [4:0]  cmd_rb;
  logic [31:0] cmd_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic        out_is_prefix;
  logic        out_is_pim;

  modport master (
    output cmd_valid, cmd_opcode, cmd_rd, cmd_ra,
    output cmd_rb, cmd_imm, out_ready,
    input  cmd_ready, out_valid, out_word,
    input  out_is_prefix, out_is_pim
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_rd, cmd_ra,
    input  cmd_rb, cmd_imm, out_ready,
    output cmd_ready, out_valid, out_word,
    output out_is_prefix, out_is_pim
  );
endinterface

// File: rtl/pim_instr_encoder.sv
// Encodes scheduler commands into MicroBlaze-format words,
// inserting an IMM prefix when a 16-bit immediate cannot hold the value.
module pim_instr_encoder #(
  parameter int CNT_W         = 16,
  parameter bit EN_IMM_PREFIX = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  pim_instr_encoder_if.slave bus,
  output logic             cmd_err,
  output logic [CNT_W-1:0] pim_cnt,
  output logic [CNT_W-1:0] mem_cnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] PREFIX = 2'd1;
  localparam logic [1:0] MAIN   = 2'd2;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]  state;
  logic [31:0] word_q;
  logic [31:0] main_q;
  logic        pfx_q;
  logic        pim_q;
  logic        main_pim_q;

  logic        is_memr;
  logic        is_memi;
  logic        is_pim;
  logic        legal;
  logic        need_pfx;
  logic        open;
  logic        accept;
  logic        fire;
  logic [15:0] low;
  logic [31:0] main_w;
  logic [31:0] pfx_w;

  always_comb begin
    is_memr = 1'b0;
    is_memi = 1'b0;
    is_pim  = 1'b0;
    case (bus.cmd_opcode)
      6'b110000, 6'b110001, 6'b110010,
      6'b110100, 6'b110101, 6'b110110: is_memr = 1'b1;
      6'b111000, 6'b111001,
      6'b111100, 6'b111101:            is_memi = 1'b1;
      6'b010100, 6'b010101, 6'b010111,
      6'b110011, 6'b110111:            is_pim  = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    low = '0;
    unique case (1'b1)
      is_memi: low = bus.cmd_imm[15:0];
      is_pim:  low = {bus.cmd_rb, bus.cmd_imm[10:0]};
      default: low = {bus.cmd_rb, 11'b0};
    endcase
  end

  assign legal  = is_memr | is_memi | is_pim;
  assign main_w = {bus.cmd_opcode, bus.cmd_rd, bus.cmd_ra, low};
  assign pfx_w  = {6'b101100, 10'b0, bus.cmd_imm[31:16]};

  // Sign-extension of imm[15] already covers the upper half: no prefix.
  assign need_pfx = EN_IMM_PREFIX && is_memi &&
                    (bus.cmd_imm[31:16] != {16{bus.cmd_imm[15]}});

  assign open   = (state == IDLE) |
                  ((state == MAIN) & bus.out_ready);
  assign accept = bus.cmd_valid & open;
  assign fire   = bus.out_valid & bus.out_ready;

  assign bus.cmd_ready     = open;
  assign bus.out_valid     = (state != IDLE);
  assign bus.out_word      = word_q;
  assign bus.out_is_prefix = pfx_q;
  assign bus.out_is_pim    = pim_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      word_q     <= '0;
      main_q     <= '0;
      pfx_q      <= 1'b0;
      pim_q      <= 1'b0;
      main_pim_q <= 1'b0;
      cmd_err    <= 1'b0;
      pim_cnt    <= '0;
      mem_cnt    <= '0;
    end else begin
      cmd_err <= accept & ~legal;
      if (fire && state == MAIN) begin
        if (pim_q) pim_cnt <= pim_cnt + ONE;
        else       mem_cnt <= mem_cnt + ONE;
      end
      case (state)
        PREFIX: begin
          if (bus.out_ready) begin
            state  <= MAIN;
            word_q <= main_q;
            pfx_q  <= 1'b0;
            pim_q  <= main_pim_q;
          end
        end
        IDLE, MAIN: begin
          if (open) begin
            if (accept && legal) begin
              state      <= need_pfx ? PREFIX : MAIN;
              word_q     <= need_pfx ? pfx_w : main_w;
              pfx_q      <= need_pfx;
              pim_q      <= is_pim;
              main_q     <= main_w;
              main_pim_q <= is_pim;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
